req_arb_4ch: RTL

REQ_ARB_4CH -- requirements
Module: req_arb_4ch

---
 rtl/req_arb_4ch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/req_arb_4ch.sv
// req_arb_4ch -- four-channel request arbiter with ack/timeout handshake.
//
// Rising edges on req[3:0] latch pending bits. When idle, one pending
// channel is granted (gnt one-hot, gnt_vld high) until the consumer acks
// or TIMEOUT_CYC cycles pass without an ack; the pending bit of that
// channel is then cleared. At least one idle cycle separates grants.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   req[3:0] in   level request lines
//   ack      in   consumer accepts current grant (ignored while idle)
//   gnt[3:0] out  registered one-hot grant or zero
//   gnt_vld  out  registered, high exactly when gnt != 0
//   timeout  out  registered one-cycle pulse on an unacknowledged expiry
//   pend[3:0]out  registered pending-request status
//
// Build option: define ROUND_ROBIN_EN for round-robin selection starting
// after the last granted channel; otherwise pend[3] has highest priority.
module req_arb_4ch #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] gnt,
  output logic       gnt_vld,
  output logic       timeout,
  output logic [3:0] pend
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  req_q;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        vld_q, vld_d;
  logic        to_q, to_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  rise;
  logic [3:0]  clr;
  logic [3:0]  sel_oh;

  assign rise = req & ~req_q;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_idx;
  logic [1:0] idx;
  logic       found;

  // Search upward from the channel after the last grant, wrapping.
  always_comb begin
    sel_oh  = '0;
    sel_idx = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && pend_q[idx]) begin
        found   = 1'b1;
        sel_idx = idx;
        sel_oh  = 4'(1) << idx;
      end
    end
  end
`else
  // Fixed priority: later (higher) indices overwrite, so pend[3] wins.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < 4; i++)
      if (pend_q[i]) sel_oh = 4'(1) << i;
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    clr     = '0;
`ifdef ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = GRANT;
          gnt_d   = sel_oh;
          vld_d   = 1'b1;
          cnt_d   = '0;
`ifdef ROUND_ROBIN_EN
          ptr_d   = sel_idx;
`endif
        end
      end
      GRANT: begin
        // cnt_q holds the number of completed grant cycles before this one,
        // so this is the last permitted cycle when it reaches TIMEOUT_CYC-1.
        // Ack is checked first so it beats a coincident expiry.
        if (ack) begin
          clr     = gnt_q;
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          clr     = gnt_q;
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          to_d    = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A rise on a channel being cleared keeps it pending.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;
  assign pend    = pend_q;

endmodule
